updown_monitor: RTL
===================

# updown_monitor

Receive-side checker for the bouncing up/down counter bus. It samples the 4-bit counter value, which is generated on a slow or fast derived clock, in the system clock domain. From that value it reconstructs count direction, step and turnaround events and the step period, and it flags any transition the bouncing counter can never legally produce. It sits between the counter output and the board-level status/LED logic.

## Interface
- WIDTH, 4, counter bus width
- STABLE, 2, consecutive identical synchronized samples required before a new value is accepted (≥1)
- PERIOD_W, 24, width of step-period measurement
- ERR_W, 8, width of error counter

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cnt_in  in  WIDTH  counter value, asynchronous to clk
- value  out  WIDTH  last accepted counter value
- value_valid  out  1  at least one value accepted since reset
- dir  out  1  1 = counting up, 0 = counting down; meaningful only in TRACK
- dir_valid  out  1  high in TRACK
- step_pulse  out  1  one-cycle pulse per legal step
- turn_pulse  out  1  one-cycle pulse on legal turnaround (at max or at 0)
- err_pulse  out  1  one-cycle pulse on illegal transition
- err_count  out  ERR_W  saturating illegal-transition count
- period  out  PERIOD_W  clk cycles between the last two accepted values
- period_valid  out  1  period holds a real measurement

## Operation
- Input capture: two-flop synchronizer per bit, then a stability filter.
  - The filter keeps a candidate and a run counter. The run counter resets to 1 when the synchronized bus differs from the candidate, and increments, saturating, otherwise.
  - A value is accepted in the cycle the run reaches STABLE and the candidate ≠ value, or in the cycle the run reaches STABLE while in INIT.
- Free-running cycle counter `gap`, saturating at 2^PERIOD_W−1, cleared on every acceptance.
- States: INIT, FIRST, TRACK.
  - INIT: the first acceptance loads value and sets value_valid. No pulses. → FIRST.
  - FIRST, on acceptance, with d = (new − value) mod 2^WIDTH:
    - d==1 and value≠max: dir=1, step_pulse. → TRACK.
    - d==2^WIDTH−1 and value≠0: dir=0, step_pulse. → TRACK.
    - else: err. Stay in FIRST.
  - TRACK, on acceptance:
    - Step in the current dir: legal, step_pulse.
    - Step against dir: legal only if the old value==max (when dir=1) or the old value==0 (when dir=0). In that case dir flips and step_pulse and turn_pulse both fire. Otherwise err.
    - Wrap max→0 or 0→max: always err.
    - |d|>1: err.
- On err:
  - err_pulse fires and err_count increments, saturating.
  - value takes the new value.
  - State → FIRST; dir_valid clears; period_valid clears.
- Period: on a legal step, period ← gap. period_valid sets on any legal step whose previous acceptance was itself a legal step or was entered from FIRST without error. The first interval after INIT is never valid.
- value is updated on every acceptance, legal or not.

## Timing
- Reset values: value=0, value_valid=0, dir=0, dir_valid=0, all pulses 0, err_count=0, period=0, period_valid=0, state INIT, synchronizer and filter cleared.
- Reset asserted mid-operation clears everything asynchronously. After release, behaviour restarts from INIT.
- Latency: if cnt_in changes cleanly before edge k, the acceptance decision is made at edge k+1+STABLE. Pulses and the updated value/dir/period are registered at edge k+2+STABLE. All pulses are exactly one cycle wide.
- Glitches shorter than STABLE synchronized samples are ignored and never counted.
- Back-to-back acceptances are legal once every STABLE+2 cycles. Pulses never merge.
- Simultaneous step+turn is the only permitted pulse overlap. err_pulse is never concurrent with step_pulse.

## Test plan
- Reset, then hold cnt_in=5 → value=5 and value_valid=1 at cycle 4; no pulses; dir_valid=0.
- Sweep 0→15→0 with 20 clk per step → 30 step_pulse; turn_pulse at 15→14 and at the final 1→0? No: turn_pulse only at 15→14. dir=1 then 0; period=20 from the second step onward; err_count=0.
- In TRACK going up at 7, jump to 9 → err_pulse, err_count=1, value=9, dir_valid=0. Next step 9→8 → dir=0, step_pulse, dir_valid=1.
- At value=15 with dir=1, apply 15→0 wrap → err_pulse. At value=0 with dir=0, apply 0→15 → err_pulse.
- 1-cycle glitch 6→4→6 while value=6 → no pulses; value stays 6.
- Assert rst mid-sweep at value=11 → all outputs return to reset values immediately; the next stable input 3 is accepted as the first value with no pulse.

Source files
------------

// File: rtl/updown_monitor.sv
// Receive-side checker for the bouncing up/down counter bus: synchronizes and
// debounces the counter value, tracks direction/steps/turnarounds, measures step period.
module updown_monitor #(
  parameter int WIDTH    = 4,
  parameter int STABLE   = 2,
  parameter int PERIOD_W = 24,
  parameter int ERR_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    cnt_in,
  output logic [WIDTH-1:0]    value,
  output logic                value_valid,
  output logic                dir,
  output logic                dir_valid,
  output logic                step_pulse,
  output logic                turn_pulse,
  output logic                err_pulse,
  output logic [ERR_W-1:0]    err_count,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid
);

  localparam int                 RUN_W    = $clog2(STABLE + 1);
  localparam logic [RUN_W-1:0]   STABLE_R = RUN_W'(STABLE);
  localparam logic [WIDTH-1:0]   MAX_V    = '1;

  typedef enum logic [1:0] {INIT, FIRST, TRACK} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] sync1, sync2;
  logic [1:0]       sync_vld;
  logic [WIDTH-1:0] cand, cand_next, ref_val, acc_val, d;
  logic [RUN_W-1:0] run, run_next;
  logic             reach, accept_d, accept_q;
  logic             up, down, step_d, turn_d, err_d, dir_next, prev_legal;
  logic [PERIOD_W-1:0] gap, gap_inc;

  // Stability filter; an acceptance still waiting to be applied is the reference value.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cand_next = cand;
    run_next  = run;
    reach     = 1'b0;
    ref_val   = accept_q ? acc_val : value;
    if (sync_vld[1]) begin
      if (run == '0 || sync2 != cand) begin
        cand_next = sync2;
        run_next  = RUN_W'(1);
      end else if (run != STABLE_R) begin
        run_next  = run + 1'b1;
      end
      reach = (run_next == STABLE_R) && (run != STABLE_R || sync2 != cand);
    end
    accept_d = reach && ((state == INIT && !accept_q) || cand_next != ref_val);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      sync_vld <= '0;
      cand     <= '0;
      run      <= '0;
      accept_q <= 1'b0;
      acc_val  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync1    <= cnt_in;
      sync2    <= sync1;
      sync_vld <= {sync_vld[0], 1'b1};
      cand     <= cand_next;
      run      <= run_next;
      accept_q <= accept_d;
      if (accept_d) acc_val <= cand_next;
    end
  end

  assign d       = acc_val - value;
  assign up      = (d == WIDTH'(1)) && (value != MAX_V);
  assign down    = (d == MAX_V) && (value != '0);
  assign gap_inc = (gap == '1) ? gap : gap + 1'b1;

  always_comb begin
    state_next = state;
    dir_next   = dir;
    step_d     = 1'b0;
    turn_d     = 1'b0;
    err_d      = 1'b0;
    if (accept_q) begin
      case (state)
        INIT: state_next = FIRST;
        FIRST: begin
          if (up || down) begin
            dir_next   = up;
            step_d     = 1'b1;
            state_next = TRACK;
          end else begin
            err_d = 1'b1;
          end
        end
        TRACK: begin
          if ((up && dir) || (down && !dir)) begin
            step_d = 1'b1;
          end else if ((down && dir && value == MAX_V) || (up && !dir && value == '0)) begin
            step_d   = 1'b1;
            turn_d   = 1'b1;
            dir_next = !dir;
          end else begin
            err_d      = 1'b1;
            state_next = FIRST;
          end
        end
        default: state_next = INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= INIT;
      value        <= '0;
      value_valid  <= 1'b0;
      dir          <= 1'b0;
      step_pulse   <= 1'b0;
      turn_pulse   <= 1'b0;
      err_pulse    <= 1'b0;
      err_count    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      prev_legal   <= 1'b0;
      gap          <= '0;
    end else begin
      state      <= state_next;
      dir        <= dir_next;
      step_pulse <= step_d;
      turn_pulse <= turn_d;
      err_pulse  <= err_d;
      gap        <= accept_q ? '0 : gap_inc;
      if (accept_q) begin
        value       <= acc_val;
        value_valid <= 1'b1;
      end
      if (err_d) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        period_valid <= 1'b0;
        prev_legal   <= 1'b0;
      end
      // A measured interval is trusted only if it started at a legal step.
      if (step_d) begin
        period       <= gap_inc;
        period_valid <= period_valid | prev_legal;
        prev_legal   <= 1'b1;
      end
    end
  end

  assign dir_valid = (state == TRACK);

endmodule
